// File: rtl/ui_debounce_array_pkg.sv
// Shared types, timing defaults and width helpers for the pushbutton
// debounce array.
package ui_debounce_pkg;

  // Per-channel event tracker: waiting for a press, pressed but not yet
  // held long enough, or held and auto-repeating.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } ui_evt_state_t;

  // Default timings at 50 MHz.
  localparam int DEBOUNCE_1MS = 50000;
  localparam int HOLD_500MS   = 25000000;
  localparam int REPEAT_100MS = 5000000;

  // Bits needed to hold the values 0..n (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ui_debounce_array_if.sv
// Bundle of raw button inputs and the cleaned-up level/event outputs.
// The master side drives the raw inputs, the slave side is the debouncer.
interface ui_debounce_array_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] inputWire_n;
  logic [CHANNELS-1:0] level_n;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] repeat_pulse;

  modport master (
    output inputWire_n,
    input  level_n,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  inputWire_n,
    output level_n,
    output press_pulse,
    output release_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/ui_debounce_array_channel.sv
// One debounced button: 2-flop synchronizer, symmetric debounce counter and
// a press/hold/repeat event tracker. Pulses line up with the level change.
module ui_debounce_channel
  import ui_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
  input  logic clock_50Mhz,
  input  logic reset,
  input  logic rawInput_n,
  output logic level_n,
  output logic pressPulse,
  output logic releasePulse,
  output logic repeatPulse
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  // With no auto-repeat the value is unused; keep it a legal constant.
  localparam logic [HW-1:0] R_LAST = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic          sync1Reg, sync2Reg;
  logic          stableReg, stableNext;
  logic [DW-1:0] dcntReg, dcntNext;
  ui_evt_state_t stateReg, stateNext;
  logic [HW-1:0] hcntReg, hcntNext;
  logic          pressReg, pressNext;
  logic          releaseReg, releaseNext;
  logic          repeatReg, repeatNext;
  logic          acceptChange, acceptFall, acceptRise;

  // Bring the asynchronous raw input into the clock domain; idles released.
  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      sync1Reg <= 1'b1;
      sync2Reg <= 1'b1;
    end else begin
      sync1Reg <= rawInput_n;
      sync2Reg <= sync1Reg;
    end
  end

  // Accept a new level only after it has differed from the stable one for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    stableNext   = stableReg;
    dcntNext     = '0;
    acceptChange = 1'b0;
    if (sync2Reg != stableReg) begin
      if (dcntReg == D_LAST) begin
        acceptChange = 1'b1;
        stableNext   = sync2Reg;
      end else begin
        dcntNext = dcntReg + DW'(1);
      end
    end
  end

  assign acceptFall = acceptChange &&  stableReg;
  assign acceptRise = acceptChange && !stableReg;

  // Event tracker: press on accepted fall, repeat on hold/repeat expiry,
  // release on accepted rise. Release wins over a coinciding repeat.
  always_comb begin
    stateNext   = stateReg;
    hcntNext    = hcntReg;
    pressNext   = 1'b0;
    releaseNext = 1'b0;
    repeatNext  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (acceptFall) begin
          stateNext = PRESSED;
          hcntNext  = '0;
          pressNext = 1'b1;
        end
      end
      PRESSED: begin
        if (acceptRise) begin
          stateNext   = IDLE;
          hcntNext    = '0;
          releaseNext = 1'b1;
        end else if (hcntReg == H_LAST) begin
          stateNext  = HELD;
          hcntNext   = '0;
          repeatNext = 1'b1;
        end else begin
          hcntNext = hcntReg + HW'(1);
        end
      end
      HELD: begin
        if (acceptRise) begin
          stateNext   = IDLE;
          hcntNext    = '0;
          releaseNext = 1'b1;
        end else if (REPEAT_CYCLES > 0) begin
          if (hcntReg == R_LAST) begin
            hcntNext   = '0;
            repeatNext = 1'b1;
          end else begin
            hcntNext = hcntReg + HW'(1);
          end
        end
      end
      default: begin
        stateNext = IDLE;
        hcntNext  = '0;
      end
    endcase
  end

  // All debounce and event state, with registered one-cycle pulses.
  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      stableReg  <= 1'b1;
      dcntReg    <= '0;
      stateReg   <= IDLE;
      hcntReg    <= '0;
      pressReg   <= 1'b0;
      releaseReg <= 1'b0;
      repeatReg  <= 1'b0;
    end else begin
      stableReg  <= stableNext;
      dcntReg    <= dcntNext;
      stateReg   <= stateNext;
      hcntReg    <= hcntNext;
      pressReg   <= pressNext;
      releaseReg <= releaseNext;
      repeatReg  <= repeatNext;
    end
  end

  assign level_n      = stableReg;
  assign pressPulse   = pressReg;
  assign releasePulse = releaseReg;
  assign repeatPulse  = repeatReg;

endmodule

// File: rtl/ui_debounce_array.sv
// Array of independent debounced buttons for the music-box UI.
module ui_debounce_array
  import ui_debounce_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
  input  logic clock_50Mhz,
  input  logic reset,
  ui_debounce_array_if.slave bus
);

  logic [CHANNELS-1:0] levelVec;
  logic [CHANNELS-1:0] pressVec;
  logic [CHANNELS-1:0] releaseVec;
  logic [CHANNELS-1:0] repeatVec;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : gChannel
    ui_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) uChannel (
      .clock_50Mhz  (clock_50Mhz),
      .reset        (reset),
      .rawInput_n   (bus.inputWire_n[gi]),
      .level_n      (levelVec[gi]),
      .pressPulse   (pressVec[gi]),
      .releasePulse (releaseVec[gi]),
      .repeatPulse  (repeatVec[gi])
    );
  end

  assign bus.level_n       = levelVec;
  assign bus.press_pulse   = pressVec;
  assign bus.release_pulse = releaseVec;
  assign bus.repeat_pulse  = repeatVec;

endmodule

// File: tb/tb_ui_debounce_array.sv
// Scoreboard bench for ui_debounce_array with short timings
// (debounce 8, hold 40, repeat 10, two channels).
module tb_ui_debounce_array;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] rep;
    logic [1:0] level;
  } exp_t;

  exp_t sbQ[$];

  ui_debounce_array_if #(.CHANNELS(2)) bus ();

  ui_debounce_array #(
    .CHANNELS        (2),
    .DEBOUNCE_CYCLES (8),
    .HOLD_CYCLES     (40),
    .REPEAT_CYCLES   (10)
  ) dut (
    .clock_50Mhz (clk),
    .reset       (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge n has happened, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExp(input int c, input logic [1:0] p, input logic [1:0] r,
                         input logic [1:0] rp, input logic [1:0] lv);
    exp_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rep = rp; e.level = lv;
    sbQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) tick();
  endtask

  // Monitor: any pulse is an output event and must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.press_pulse | bus.release_pulse | bus.repeat_pulse) != 2'b00) begin
      if (sbQ.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_pulse: cyc %0d press %b release %b repeat %b level %b, none required",
                 cyc, bus.press_pulse, bus.release_pulse, bus.repeat_pulse, bus.level_n);
      end else begin
        e = sbQ.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("press_pulse", {30'd0, bus.press_pulse}, {30'd0, e.press});
        check("release_pulse", {30'd0, bus.release_pulse}, {30'd0, e.rel});
        check("repeat_pulse", {30'd0, bus.repeat_pulse}, {30'd0, e.rep});
        check("level_n", {30'd0, bus.level_n}, {30'd0, e.level});
        $display("event cyc %0d press %b release %b repeat %b level %b",
                 cyc, bus.press_pulse, bus.release_pulse, bus.repeat_pulse, bus.level_n);
      end
    end
  end

  initial begin
    int e0;
    int p0;
    bus.inputWire_n = 2'b11;

    // Reset state
    #12;
    check("reset_level_n", {30'd0, bus.level_n}, 32'h3);
    check("reset_pulses", {26'd0, bus.press_pulse, bus.release_pulse, bus.repeat_pulse}, 32'h0);
    tick();
    #2 rst = 1'b0;
    repeat (3) tick();

    // Clean press on ch0: level and press pulse at edge 0 + 9
    bus.inputWire_n = 2'b10;
    e0 = cyc + 1;
    pushExp(e0 + 9, 2'b01, 2'b00, 2'b00, 2'b10);
    repeat (12) tick();

    // Debounced release with a low bounce at edges 2-4; final high at edge 5
    bus.inputWire_n = 2'b11;
    e0 = cyc + 1;
    pushExp(e0 + 14, 2'b00, 2'b01, 2'b00, 2'b11);
    repeat (2) tick();
    bus.inputWire_n = 2'b10;
    repeat (3) tick();
    bus.inputWire_n = 2'b11;
    repeat (20) tick();

    // Glitch of 7 cycles is ignored
    bus.inputWire_n = 2'b10;
    repeat (7) tick();
    bus.inputWire_n = 2'b11;
    repeat (15) tick();

    // 8 low cycles are accepted, then released
    bus.inputWire_n = 2'b10;
    e0 = cyc + 1;
    pushExp(e0 + 9, 2'b01, 2'b00, 2'b00, 2'b10);
    pushExp(e0 + 17, 2'b00, 2'b01, 2'b00, 2'b11);
    repeat (8) tick();
    bus.inputWire_n = 2'b11;
    repeat (20) tick();

    // Hold: repeats at press+40,+50..+90, release lands at press+95
    bus.inputWire_n = 2'b10;
    e0 = cyc + 1;
    p0 = e0 + 9;
    pushExp(p0, 2'b01, 2'b00, 2'b00, 2'b10);
    for (int k = 0; k < 6; k++) pushExp(p0 + 40 + 10 * k, 2'b00, 2'b00, 2'b01, 2'b10);
    pushExp(p0 + 95, 2'b00, 2'b01, 2'b00, 2'b11);
    waitUntil(p0 + 85);
    bus.inputWire_n = 2'b11;
    repeat (20) tick();

    // Both channels together; release coincides with the first repeat expiry
    bus.inputWire_n = 2'b00;
    e0 = cyc + 1;
    p0 = e0 + 9;
    pushExp(p0, 2'b11, 2'b00, 2'b00, 2'b00);
    pushExp(p0 + 40, 2'b00, 2'b11, 2'b00, 2'b11);
    waitUntil(p0 + 30);
    bus.inputWire_n = 2'b11;
    repeat (20) tick();

    // Reset asserted mid-hold between edges
    bus.inputWire_n = 2'b10;
    e0 = cyc + 1;
    p0 = e0 + 9;
    pushExp(p0, 2'b01, 2'b00, 2'b00, 2'b10);
    pushExp(p0 + 40, 2'b00, 2'b00, 2'b01, 2'b10);
    waitUntil(p0 + 45);
    #2 rst = 1'b1;
    #1;
    check("midreset_level_n", {30'd0, bus.level_n}, 32'h3);
    check("midreset_pulses", {26'd0, bus.press_pulse, bus.release_pulse, bus.repeat_pulse}, 32'h0);
    repeat (3) tick();
    #2 rst = 1'b0;
    e0 = cyc + 1;
    pushExp(e0 + 9, 2'b01, 2'b00, 2'b00, 2'b10);
    repeat (15) tick();
    bus.inputWire_n = 2'b11;
    e0 = cyc + 1;
    pushExp(e0 + 9, 2'b00, 2'b01, 2'b00, 2'b11);
    repeat (20) tick();

    check("queue_drained", sbQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ui_debounce_array.md
Name: ui_debounce_array

Overview:
- Multi-channel successor to the single-trigger smoother: debounces CHANNELS raw active-low button/switch inputs.
- Per channel, emits a clean active-low level plus one-cycle press, release and hold/auto-repeat event pulses.
- Sits between the board pushbuttons/switches and the music-box UI control logic, all on the 50 MHz clock.

Parameters:
- CHANNELS, 4: number of independent inputs (>=1).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a change, both press and release (>=1).
- HOLD_CYCLES, 25000000: cycles held after press before the first repeat pulse (0.5 s; >=1).
- REPEAT_CYCLES, 5000000: cycles between subsequent repeat pulses while held (0.1 s). 0 means one hold pulse only.

Ports:
- clock_50Mhz  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- inputWire_n  input  CHANNELS  raw asynchronous inputs, active-low, bit i = channel i.
- level_n  output  CHANNELS  debounced level, active-low.
- press_pulse  output  CHANNELS  one-cycle high on accepted press.
- release_pulse  output  CHANNELS  one-cycle high on accepted release.
- repeat_pulse  output  CHANNELS  one-cycle high on hold/auto-repeat.

Behaviour:
- Interface: one clock (clock_50Mhz). reset is asynchronous and active-high.
- Reset values:
  - level_n all 1. All pulses 0.
  - Synchronizer flops 1. All counters 0. All channels in IDLE.
  - Reset asserted mid-operation aborts everything immediately. No pulse is emitted on reset assertion or deassertion.
- Synchronizer: 2-flop per channel (s1, s2); only s2 is used downstream.
- Debounce (per channel):
  - stable reg drives level_n. Counter dcnt has width $clog2(DEBOUNCE_CYCLES+1).
  - Each edge: if s2 != stable:
    - if dcnt == DEBOUNCE_CYCLES-1, then stable <= s2 and dcnt <= 0;
    - else dcnt <= dcnt+1.
  - If s2 == stable, dcnt <= 0.
  - Latency: raw first sampled changed at edge 0 -> level_n changes after edge DEBOUNCE_CYCLES+1.
  - A glitch lasting DEBOUNCE_CYCLES-1 s2-cycles is ignored and produces no event.
  - Release is debounced symmetrically. This is new behaviour; release is no longer immediate.
- Event FSM (per channel), states IDLE, PRESSED, HELD:
  - IDLE -> PRESSED on stable 1->0. press_pulse=1 on the same edge level_n falls. hcnt <= 0.
  - PRESSED: hcnt increments each edge. When hcnt == HOLD_CYCLES-1: repeat_pulse=1, hcnt <= 0, go to HELD.
  - HELD with REPEAT_CYCLES>0: hcnt increments. When hcnt == REPEAT_CYCLES-1: repeat_pulse=1, hcnt <= 0, stay in HELD.
  - HELD with REPEAT_CYCLES=0: idle in HELD; no further pulses.
  - PRESSED or HELD -> IDLE on stable 0->1. release_pulse=1 on the same edge level_n rises. hcnt <= 0.
  - Release takes priority: if release and a repeat expiry coincide, only release_pulse fires.
- Pulses:
  - All pulses are registered, exactly one cycle wide, and mutually exclusive per channel.
  - Channels are fully independent; simultaneous events on several channels assert several bits in the same cycle.
- Widths: hcnt width = $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1). Counters saturate by construction and never wrap.

Decomposition:
- Package ui_debounce_pkg:
  - ui_evt_state_t enum {IDLE, PRESSED, HELD}.
  - Width helper function cnt_width(n) = $clog2(n+1).
  - Default timing constants DEBOUNCE_1MS=50000, HOLD_500MS=25000000, REPEAT_100MS=5000000.
- Sub-module ui_debounce_channel: one channel (synchronizer, debounce counter, event FSM).
- Top level instantiates CHANNELS copies in a generate loop.

Test Plan:
Bench parameters: CHANNELS=2, DEBOUNCE_CYCLES=8, HOLD_CYCLES=40, REPEAT_CYCLES=10.
- Clean press: ch0 driven low at edge 0 and held -> level_n[0]=0 after edge 9; press_pulse[0] high exactly one cycle at edge 9; ch1 untouched.
- Glitch reject: ch0 low for 7 cycles, then high -> no level change, no pulses. Then low for 8 cycles -> press accepted.
- Debounced release: after press, raw high at edge 0, with a 3-cycle low bounce at edges 2-4 -> counter restarts. level_n[0] rises 9 edges after the final high transition; release_pulse one cycle.
- Hold/repeat: hold ch0 low 100 cycles after press -> repeat_pulse at press+40, +50, +60, +70, +80, +90 cycles; release -> release_pulse, no further repeats.
- Simultaneous/priority: both channels pressed same edge -> press_pulse=2'b11 one cycle. Release timed so expiry coincides with a repeat -> release_pulse only.
- Reset mid-hold: assert reset asynchronously between clock edges while in HELD -> level_n=2'b11 and pulses 0 immediately. After deassert with input still low -> fresh press after 9 edges, no spurious release_pulse.
